// File: rtl/exc_ctrl_pkg.sv
// exc_pkg: shared types and constants for the external-interrupt exception
// controller (exc_ctrl) and its interface.
//   exc_state_t  - controller FSM state
//   ESTATUS_W    - width of the EStatus cause code
//   EXC_EXT_BASE - base cause code for external lines (codes 8..15)
//   ext_code()   - cause code for a given line index
package exc_pkg;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} exc_state_t;

    localparam int ESTATUS_W = 4;
    localparam logic [ESTATUS_W-1:0] EXC_EXT_BASE = 4'b1000;

    // Codes 1..7 belong to datapath-internal causes; external lines map to 8..15.
    function automatic logic [ESTATUS_W-1:0] ext_code(input logic [2:0] src);
        return EXC_EXT_BASE | {1'b0, src};
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: exception handshake bundle between exc_ctrl and the datapath.
//   IRQ, IRQMask     - interrupt lines and per-line mask (1 = masked)
//   ExcAck, ERet     - datapath accepted the exception / executing ERET
//   Exc, EStatus     - exception request and cause code
//   Pending, Busy    - captured edges, controller not idle
//   AckErr           - sticky ack-timeout flag
// modport master: the controller (exc_ctrl); modport slave: datapath/environment.
interface exc_ctrl_if #(
    parameter int NSRC = 4
);
    import exc_pkg::*;

    logic [NSRC-1:0]      IRQ;
    logic [NSRC-1:0]      IRQMask;
    logic                 ExcAck;
    logic                 ERet;
    logic                 Exc;
    logic [ESTATUS_W-1:0] EStatus;
    logic [NSRC-1:0]      Pending;
    logic                 Busy;
    logic                 AckErr;

    modport master (
        input  IRQ, IRQMask, ExcAck, ERet,
        output Exc, EStatus, Pending, Busy, AckErr
    );

    modport slave (
        output IRQ, IRQMask, ExcAck, ERet,
        input  Exc, EStatus, Pending, Busy, AckErr
    );

endinterface

// File: rtl/exc_ctrl_irq_prio_enc.sv
// irq_prio_enc: combinational priority encoder, lowest set bit wins.
//   cand - candidate request vector
//   any  - at least one bit set
//   idx  - index of the lowest set bit (0 when none)
module irq_prio_enc #(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] cand,
    output logic            any,
    output logic [2:0]      idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (cand[i] && !any) begin
                any = 1'b1;
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: external-interrupt exception controller. Captures rising edges on
// NSRC lines into Pending, requests the lowest-index unmasked pending line via
// Exc/EStatus, waits for ExcAck, then blocks until ERet (no nesting).
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - exc_ctrl_if.master (IRQ, IRQMask, ExcAck, ERet in;
//           Exc, EStatus, Pending, Busy, AckErr out)
// Optional macro EXC_ACK_TIMEOUT_EN: abandon a request after TIMEOUT cycles
// in REQ without ExcAck and set sticky AckErr; otherwise AckErr is tied 0.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int NSRC    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    exc_ctrl_if.master bus
);

    if (NSRC < 1 || NSRC > 8 || TIMEOUT < 1) begin : g_param_check
        $error("exc_ctrl: NSRC must be 1..8 and TIMEOUT >= 1");
    end

    exc_state_t           state_q, state_d;
    logic [2:0]           src_q, src_d;
    logic [NSRC-1:0]      irq_q, irq_d;
    logic [NSRC-1:0]      pending_q, pending_d;
    logic                 exc_q, exc_d;
    logic                 busy_q, busy_d;
    logic [ESTATUS_W-1:0] estatus_q, estatus_d;

    logic [NSRC-1:0]      irq_rise;
    logic [NSRC-1:0]      cand;
    logic [NSRC-1:0]      clr;
    logic                 cand_any;
    logic [2:0]           cand_idx;

`ifdef EXC_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ackerr_q, ackerr_d;
`endif

    assign irq_rise = bus.IRQ & ~irq_q;
    // Masked lines still accumulate in Pending; they are only kept out of arbitration.
    assign cand     = pending_q & ~bus.IRQMask;

    irq_prio_enc #(.NSRC(NSRC)) u_prio (
        .cand (cand),
        .any  (cand_any),
        .idx  (cand_idx)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        clr     = '0;
`ifdef EXC_ACK_TIMEOUT_EN
        cnt_d    = cnt_q;
        ackerr_d = ackerr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cand_any) begin
                    state_d = REQ;
                    src_d   = cand_idx;
`ifdef EXC_ACK_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                if (bus.ExcAck) begin
                    state_d = SERVICE;
                    for (int unsigned i = 0; i < NSRC; i++) begin
                        clr[i] = (src_q == 3'(i));
                    end
                end
`ifdef EXC_ACK_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Pending[src] is left set so the line re-arbitrates from IDLE.
                    state_d  = IDLE;
                    ackerr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            SERVICE: begin
                if (bus.ERet) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge on the line being acknowledged wins over the clear.
        pending_d = (pending_q & ~clr) | irq_rise;
        irq_d     = bus.IRQ;

        // Outputs are registered copies decoded from the next state.
        exc_d     = (state_d == REQ);
        busy_d    = (state_d != IDLE);
        estatus_d = (state_d == IDLE) ? '0 : ext_code(src_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            irq_q     <= '0;
            pending_q <= '0;
            exc_q     <= 1'b0;
            busy_q    <= 1'b0;
            estatus_q <= '0;
`ifdef EXC_ACK_TIMEOUT_EN
            cnt_q     <= '0;
            ackerr_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            irq_q     <= irq_d;
            pending_q <= pending_d;
            exc_q     <= exc_d;
            busy_q    <= busy_d;
            estatus_q <= estatus_d;
`ifdef EXC_ACK_TIMEOUT_EN
            cnt_q     <= cnt_d;
            ackerr_q  <= ackerr_d;
`endif
        end
    end

    assign bus.Exc     = exc_q;
    assign bus.EStatus = estatus_q;
    assign bus.Pending = pending_q;
    assign bus.Busy    = busy_q;
`ifdef EXC_ACK_TIMEOUT_EN
    assign bus.AckErr  = ackerr_q;
`else
    assign bus.AckErr  = 1'b0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: self-checking bench for exc_ctrl. Directed handshake scenarios
// followed by randomized IRQ/mask/ack/eret traffic, all compared cycle by
// cycle against a behavioural model of the exception controller.
module tb_exc_ctrl;
    import exc_pkg::*;

    localparam int NSRC    = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    exc_ctrl_if #(.NSRC(NSRC)) bus ();

    exc_ctrl #(.NSRC(NSRC), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Behavioural model state
    bit [3:0] m_hist;
    bit [3:0] m_pend;
    bit       m_requesting;
    bit       m_servicing;
    int       m_src;
    int       m_req_cycles;
    bit       m_ackerr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_hist       = '0;
        m_pend       = '0;
        m_requesting = 1'b0;
        m_servicing  = 1'b0;
        m_src        = 0;
        m_req_cycles = 0;
        m_ackerr     = 1'b0;
    endfunction

    // One clock of the controller, from the inputs present at this edge.
    function automatic void model_step();
        bit [3:0] rise;
        bit [3:0] cleared;
        bit [3:0] ready;
        bit [3:0] lowest;
        rise    = bit'(1) ? (bus.IRQ & ~m_hist) : '0;
        cleared = '0;
        ready   = m_pend & ~bus.IRQMask;
        if (m_requesting) begin
            m_req_cycles++;
            if (bus.ExcAck) begin
                cleared[m_src] = 1'b1;
                m_requesting   = 1'b0;
                m_servicing    = 1'b1;
            end
`ifdef EXC_ACK_TIMEOUT_EN
            else if (m_req_cycles == TIMEOUT) begin
                m_requesting = 1'b0;
                m_ackerr     = 1'b1;
            end
`endif
        end else if (m_servicing) begin
            if (bus.ERet) m_servicing = 1'b0;
        end else if (ready != 0) begin
            lowest       = ready & (~ready + 4'd1);
            m_src        = $clog2(lowest);
            m_requesting = 1'b1;
            m_req_cycles = 0;
        end
        m_pend = (m_pend & ~cleared) | rise;
        m_hist = bus.IRQ;
    endfunction

    task automatic check_outputs(input string tag);
        int exp_status;
        exp_status = (m_requesting || m_servicing) ? (8 + m_src) : 0;
        check({tag, "_exc"},     32'(bus.Exc),     32'(m_requesting));
        check({tag, "_estatus"}, 32'(bus.EStatus), 32'(exp_status));
        check({tag, "_busy"},    32'(bus.Busy),    32'(m_requesting || m_servicing));
        check({tag, "_pending"}, 32'(bus.Pending), 32'(m_pend));
        check({tag, "_ackerr"},  32'(bus.AckErr),  32'(m_ackerr));
    endtask

    task automatic drive(input logic [3:0] irq, input logic [3:0] mask,
                         input logic ack, input logic eret);
        bus.IRQ     = irq;
        bus.IRQMask = mask;
        bus.ExcAck  = ack;
        bus.ERet    = eret;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        // Line 0 held high through reset.
        drive(4'b0001, 4'b0000, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #2;
        check_outputs("rst");
        cycle("rst_hold");
        @(negedge clk) reset = 1'b0;

        // Exactly one request for the held line, Exc two edges after first sample.
        cycle("t1_capture");
        check("t1_pend", 32'(bus.Pending), 32'h1);
        check("t1_exc_low", 32'(bus.Exc), 32'h0);
        cycle("t1_req");
        check("t1_exc_high", 32'(bus.Exc), 32'h1);
        check("t1_code", 32'(bus.EStatus), 32'h8);
        drive(4'b0001, 4'b0000, 1'b1, 1'b0);
        cycle("t1_ack");
        drive(4'b0001, 4'b0000, 1'b0, 1'b1);
        cycle("t1_eret");
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        cycle("t1_idle");
        check("t1_no_rereq", 32'(bus.Exc), 32'h0);

        // Lines 1 and 2 together: line 1 first, then line 2.
        drive(4'b0110, 4'b0000, 1'b0, 1'b0);
        cycle("t2_capture");
        cycle("t2_req1");
        check("t2_code1", 32'(bus.EStatus), 32'h9);
        drive(4'b0110, 4'b0000, 1'b1, 1'b0);
        cycle("t2_ack1");
        check("t2_pend_svc", 32'(bus.Pending), 32'h4);
        drive(4'b0110, 4'b0000, 1'b0, 1'b1);
        cycle("t2_eret1");
        drive(4'b0110, 4'b0000, 1'b0, 1'b0);
        cycle("t2_req2");
        check("t2_code2", 32'(bus.EStatus), 32'hA);
        drive(4'b0110, 4'b0000, 1'b1, 1'b0);
        cycle("t2_ack2");
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        cycle("t2_eret2");

        // Masked line captures but does not request until unmasked.
        drive(4'b0010, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("t3_masked");
        check("t3_pend", 32'(bus.Pending), 32'h2);
        check("t3_exc_low", 32'(bus.Exc), 32'h0);
        drive(4'b0010, 4'b0000, 1'b0, 1'b0);
        cycle("t3_unmask");
        check("t3_code", 32'(bus.EStatus), 32'h9);
        drive(4'b0010, 4'b0000, 1'b1, 1'b0);
        cycle("t3_ack");
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        cycle("t3_eret");

        // New edge on the acknowledged line in the ack cycle survives.
        drive(4'b0001, 4'b0000, 1'b0, 1'b0);
        cycle("t4_capture");
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        cycle("t4_req");
        drive(4'b0001, 4'b0000, 1'b1, 1'b0);
        cycle("t4_ack_edge");
        check("t4_pend_kept", 32'(bus.Pending), 32'h1);
        drive(4'b0001, 4'b0000, 1'b0, 1'b1);
        cycle("t4_eret");
        drive(4'b0001, 4'b0000, 1'b0, 1'b0);
        cycle("t4_rereq");
        check("t4_rereq_exc", 32'(bus.Exc), 32'h1);

        // ERet in REQ and ExcAck in SERVICE are ignored; reset mid-service.
        drive(4'b0001, 4'b0000, 1'b0, 1'b1);
        cycle("t5_eret_in_req");
        check("t5_still_req", 32'(bus.Exc), 32'h1);
        drive(4'b0001, 4'b0000, 1'b1, 1'b0);
        cycle("t5_ack");
        drive(4'b0101, 4'b0000, 1'b1, 1'b0);
        cycle("t5_ack_in_svc");
        check("t5_still_svc", 32'(bus.Busy), 32'h1);
        drive(4'b0101, 4'b0000, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b1;
        #1;
        model_reset();
        check("t5_rst_exc", 32'(bus.Exc), 32'h0);
        check("t5_rst_code", 32'(bus.EStatus), 32'h0);
        check("t5_rst_busy", 32'(bus.Busy), 32'h0);
        check("t5_rst_pend", 32'(bus.Pending), 32'h0);
        cycle("t5_rst_hold");
        @(negedge clk) reset = 1'b0;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("t5_recover");
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        cycle("t5_drain");
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        cycle("t5_drain2");

`ifdef EXC_ACK_TIMEOUT_EN
        // No ack: request abandoned after TIMEOUT cycles, then re-raised.
        drive(4'b1000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT + 2; i++) cycle("t6_wait");
        check("t6_ackerr", 32'(bus.AckErr), 32'h1);
        cycle("t6_rereq");
        check("t6_rereq_exc", 32'(bus.Exc), 32'h1);
        check("t6_rereq_code", 32'(bus.EStatus), 32'hB);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] irq;
            logic [3:0] mask;
            irq  = bus.IRQ;
            mask = bus.IRQMask;
            if ($urandom_range(0, 2) == 0) irq[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) mask = 4'($urandom_range(0, 15));
            drive(irq, mask, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- External-interrupt exception controller: the source end of the Exc / EStatus / ExcAck / ERet exception handshake that the single-cycle LEGv8 datapath consumes.
- Captures rising edges on up to 8 interrupt lines and holds them as pending.
- Selects the highest-priority unmasked pending line, raises Exc with an EStatus code, and waits for ExcAck from the datapath.
- Blocks further requests until the handler executes ERET (ERet control pulse). No nesting.

Parameters:
- NSRC, 4, number of interrupt lines (1..8).
- TIMEOUT, 16, cycles allowed in REQ before ack-timeout (only with EXC_ACK_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IRQ  in  NSRC  interrupt lines, rising-edge sensitive.
- IRQMask  in  NSRC  1 = line masked; edge still captured into Pending.
- ExcAck  in  1  datapath accepted exception (exception vector taken).
- ERet  in  1  datapath executing ERET; one-cycle pulse.
- Exc  out  1  exception request to datapath.
- EStatus  out  4  exception cause code.
- Pending  out  NSRC  captured, not-yet-acknowledged edges.
- Busy  out  1  state != IDLE.
- AckErr  out  1  sticky ack-timeout flag; constant 0 without the macro.

Behaviour:
- Decided: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: state IDLE, Pending 0, IRQ history register 0, Exc 0, EStatus 0, Busy 0, AckErr 0.
  - History resets to 0, so a line held high through reset yields exactly one request.
- Edge capture: edge[i] = IRQ[i] & ~IRQ_q[i]. An edge sets Pending[i] at that clock edge, in any state.
- Qualified set: cand = Pending & ~IRQMask. Lowest index has highest priority.
- FSM: IDLE, REQ, SERVICE. All outputs are registered or decoded from registered state only.
  - IDLE: if cand != 0, latch src = priority index and move to REQ. Otherwise stay.
  - REQ: Exc = 1 and EStatus = 4'b1000 | src.
    - On ExcAck: clear Pending[src] and move to SERVICE.
    - Mask changes in REQ do not retract the latched request.
  - SERVICE: Exc = 0; EStatus holds its code. On ERet, move to IDLE.
  - IDLE: EStatus = 0.
- Latency: IRQ[i] sampled high at edge n (low at n-1) → Pending[i] = 1 after edge n → Exc = 1 after edge n+1.
  - Exc drops the edge after ExcAck is sampled.
- Ignored inputs: ExcAck in IDLE/SERVICE; ERet in IDLE/REQ.
- Simultaneous edge on line src and ExcAck clearing it: set wins, Pending[src] stays 1. The new edge is serviced after ERET.
- Back-to-back: after ERet → IDLE, a remaining cand is selected on the next edge. There is no extra idle cycle beyond the IDLE state itself.
- EStatus codes 1..7 are reserved for datapath-internal causes; this block only emits 8..15.
- Reset asserted mid-handshake: immediately IDLE, Exc 0, all pending lost.

Optional Feature:
- Macro: EXC_ACK_TIMEOUT_EN.
- With the macro:
  - A counter clears on REQ entry and increments each cycle in REQ.
  - If it reaches TIMEOUT without ExcAck: Exc drops, AckErr sets (sticky until reset), state returns to IDLE.
  - Pending[src] is kept, so the request re-arbitrates next cycle.
- Without the macro: no counter, REQ waits indefinitely, AckErr tied 0.

Decomposition:
- Package exc_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, SERVICE} exc_state_t;
  - localparam EXC_EXT_BASE = 4'b1000;
  - localparam ESTATUS_W = 4.
- One sub-module: irq_prio_enc (#NSRC), combinational.
  - Inputs: cand.
  - Outputs: any, idx[2:0] (lowest set bit).

Test Plan:
- Reset with IRQ = 4'b0001 held → after release, Pending = 0001; Exc rises 2 edges after first sample; EStatus = 4'h8.
- IRQ[2] and IRQ[1] rise same cycle, ExcAck 1 cycle after Exc → EStatus = 4'h9 first, Pending = 0100 in SERVICE; after ERet, EStatus = 4'hA.
- IRQMask = 0010, edge on IRQ[1] → Pending = 0010, Exc stays 0. Clear mask → Exc after 1 edge, EStatus = 4'h9.
- In REQ for src 0: new edge on IRQ[0] the same cycle as ExcAck → Pending[0] stays 1; re-requested after ERet.
- ERet pulse in REQ and ExcAck in SERVICE → no state change. Reset asserted in SERVICE → Exc 0, EStatus 0, Busy 0 asynchronously.
- With EXC_ACK_TIMEOUT_EN, TIMEOUT = 16, no ExcAck → Exc low after 16 REQ cycles, AckErr = 1, Exc re-raised next arbitration with the same EStatus.
